vslc_prog_loader: RTL and testbench
===================================

// Module: vslc_prog_loader
// PURPOSE
//  Upstream program loader for the VSLC stack-logic core. Receives a framed byte stream
//  over valid/ready, validates length and checksum, and unpacks it into 4-bit code-memory
//  writes. Pads unused slots with NOP (4'hF). Raises prog_ok when the core may execute.
// PARAMETERS
//  CODE_DEPTH  32     code-memory entries (nibbles)
//  ADDR_W      5      code-memory address width, log2(CODE_DEPTH)
//  NOP_OP      4'hF   opcode written to the unused slots at L..CODE_DEPTH-1
// PORTS
//  clk        in   1       only clock; every state change is on its rising edge
//  rst        in   1       synchronous, active-high reset
//  load_start in   1       one-cycle pulse: begin (or restart) a load
//  in_valid   in   1       in_data is valid this cycle
//  in_data    in   8       frame byte
//  in_ready   out  1       loader accepts in_data; combinational from state only
//  wr_en      out  1       registered code-memory write strobe
//  wr_addr    out  ADDR_W  registered write address
//  wr_data    out  4       registered write nibble
//  busy       out  1       high in any state other than IDLE
//  done       out  1       one-cycle pulse when a load completes successfully
//  prog_ok    out  1       level; a valid program is resident
//  err_len    out  1       sticky; bad length byte
//  err_csum   out  1       sticky; checksum mismatch
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  Reset: state=IDLE; all outputs 0; byte index, length and sum cleared. Reset overrides all
//   other inputs, including during an active load.
//  Frame: LEN byte L (valid 1..CODE_DEPTH), then (L+1)>>1 data bytes, then CSUM byte.
//   Each data byte carries the low nibble first (lower address), then the high nibble.
//   Checksum rule: 8-bit wrapping sum of every frame byte, CSUM included, must equal 8'h00.
//  Handshake: a byte transfers at an edge where in_valid & in_ready. in_ready=1 only in LEN,
//   DATA_LO and CSUM.
//  FSM:
//   IDLE    -> LEN on load_start. Clears err_*, prog_ok and the sum.
//   LEN     -> on transfer: if L==0 or L>CODE_DEPTH, set err_len and go to ERR;
//              else latch L and go to DATA_LO.
//   DATA_LO -> on transfer: register wr_en=1, wr_addr=idx, wr_data=byte[3:0]; latch byte[7:4];
//              go to DATA_HI.
//   DATA_HI -> in_ready=0. If idx+1<L, register a write of the high nibble at idx+1.
//              idx+=2. Go to CSUM when idx>=L, else go to DATA_LO.
//   CSUM    -> on transfer: if the sum is 0, go to FILL (or straight to FIN when L==CODE_DEPTH);
//              else set err_csum and go to ERR.
//   FILL    -> one write per cycle of NOP_OP at addresses L..CODE_DEPTH-1, then go to FIN.
//   FIN     -> done=1 for this one cycle; prog_ok<=1; go to IDLE.
//   ERR     -> no writes; err_* holds; leave only on load_start (to LEN) or rst.
//  Throughput: 2 cycles per data byte. After the CSUM edge, FILL takes CODE_DEPTH-L cycles.
//  wr_en is 0 in every cycle that is not named above as a write.
//  load_start in any state other than IDLE: abort, go to LEN, clear err_*/prog_ok/sum/idx.
//   No byte is accepted in that cycle, and memory is left partially written.
//  load_start together with in_valid: load_start wins; the byte is not consumed.
//  The sum wraps mod 256. idx is ADDR_W+1 bits so that idx==CODE_DEPTH does not alias to 0.
//  prog_ok=0 from load_start until FIN. The core must gate execution on prog_ok.
// STRUCTURE
//  vslc_pkg: CODE_DEPTH, NOP_OP, the opcode localparams shared with the core, and the
//   loader state encoding.
//  Single module; no sub-modules. The checksum accumulator is an inline register.
// TESTING
//  1. L=3: bytes 03,50,09,A4 -> writes (0,0),(1,5),(2,9), then F at addrs 3..31 (29 writes),
//     done pulse, prog_ok=1. The high nibble 0 of byte 09 is never written.
//  2. Same frame with CSUM=A5 -> err_csum=1, prog_ok=0, done never pulses, no FILL writes.
//  3. LEN=00, then a separate load with LEN=21 -> err_len=1 on the next cycle, in_ready=0,
//     zero writes.
//  4. L=32 (20), 16 data bytes, in_valid held high -> in_ready toggles 1,0. 32 writes,
//     no FILL, done pulse.
//  5. rst asserted after the 2nd data byte -> next cycle all outputs 0, state IDLE,
//     no later writes.
//  6. load_start during DATA_HI, then a clean L=1 frame 01,07,F8 -> errors cleared,
//     write (0,7), fill 1..31, prog_ok=1.

Source files
------------

// File: rtl/vslc_prog_loader_pkg.sv
// VSLC program loader: shared sizes, NOP opcode
// and loader state encoding.
package vslc_prog_loader_pkg;

  localparam int CODE_DEPTH = 32;
  localparam int ADDR_W     = 5;
  localparam logic [3:0] NOP_OP = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA_LO,
    S_DATA_HI,
    S_CSUM,
    S_FILL,
    S_FIN,
    S_ERR
  } ld_state_e;

  function automatic logic len_bad(input logic [7:0] b);
    return (b == 8'd0) || (b > 8'(CODE_DEPTH));
  endfunction

endpackage

// File: rtl/vslc_prog_loader_if.sv
// Byte-stream valid/ready link feeding the
// program loader.
interface vslc_prog_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/vslc_prog_loader.sv
// Framed byte-stream loader: checks length and
// checksum, writes nibbles, pads with NOP.
module vslc_prog_loader
  import vslc_prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  vslc_prog_loader_if.slave bus,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [3:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic              prog_ok,
  output logic              err_len,
  output logic              err_csum
);

  localparam logic [ADDR_W:0] DEPTH =
    (ADDR_W+1)'(CODE_DEPTH);

  ld_state_e       state, nxt;
  logic [ADDR_W:0] idx, len;
  logic [ADDR_W:0] idx_p1, idx_p2;
  logic [7:0]      sum, sum_nxt;
  logic [3:0]      hi;
  logic            rdy, xfer;

  assign rdy = (state == S_LEN)
            || (state == S_DATA_LO)
            || (state == S_CSUM);
  assign bus.in_ready = rdy;
  assign xfer = bus.in_valid & rdy & ~load_start;

  assign idx_p1  = idx + 1'b1;
  assign idx_p2  = idx + 2'd2;
  assign sum_nxt = sum + bus.in_data;

  assign busy = (state != S_IDLE);
  assign done = (state == S_FIN);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:    nxt = state;
      S_LEN:
        if (xfer)
          nxt = len_bad(bus.in_data)
              ? S_ERR : S_DATA_LO;
      S_DATA_LO: if (xfer) nxt = S_DATA_HI;
      S_DATA_HI:
        nxt = (idx_p2 >= len) ? S_CSUM : S_DATA_LO;
      S_CSUM:
        if (xfer) begin
          if (sum_nxt != 8'd0) nxt = S_ERR;
          else if (len == DEPTH) nxt = S_FIN;
          else nxt = S_FILL;
        end
      S_FILL:
        if (idx == DEPTH - 1'b1) nxt = S_FIN;
      S_FIN:     nxt = S_IDLE;
      S_ERR:     nxt = state;
    endcase
    if (load_start) nxt = S_LEN;
  end

  // abort on load_start suppresses any pending write
  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      len      <= '0;
      sum      <= '0;
      hi       <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      prog_ok  <= 1'b0;
      err_len  <= 1'b0;
      err_csum <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (load_start) begin
        idx      <= '0;
        sum      <= '0;
        prog_ok  <= 1'b0;
        err_len  <= 1'b0;
        err_csum <= 1'b0;
      end else begin
        unique case (state)
          S_LEN:
            if (xfer) begin
              sum <= sum_nxt;
              if (len_bad(bus.in_data))
                err_len <= 1'b1;
              else
                len <= bus.in_data[ADDR_W:0];
            end
          S_DATA_LO:
            if (xfer) begin
              sum     <= sum_nxt;
              wr_en   <= 1'b1;
              wr_addr <= idx[ADDR_W-1:0];
              wr_data <= bus.in_data[3:0];
              hi      <= bus.in_data[7:4];
            end
          S_DATA_HI: begin
            if (idx_p1 < len) begin
              wr_en   <= 1'b1;
              wr_addr <= idx_p1[ADDR_W-1:0];
              wr_data <= hi;
            end
            idx <= idx_p2;
          end
          S_CSUM:
            if (xfer) begin
              sum <= sum_nxt;
              idx <= len;
              if (sum_nxt != 8'd0)
                err_csum <= 1'b1;
            end
          S_FILL: begin
            wr_en   <= 1'b1;
            wr_addr <= idx[ADDR_W-1:0];
            wr_data <= NOP_OP;
            idx     <= idx_p1;
          end
          S_FIN:  prog_ok <= 1'b1;
          S_IDLE, S_ERR: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vslc_prog_loader.sv
// Scoreboard bench for vslc_prog_loader:
// directed frames, write queue checked by a monitor.
module tb_vslc_prog_loader;
  import vslc_prog_loader_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_start;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [3:0] wr_data;
  logic       busy, done, prog_ok;
  logic       err_len, err_csum;

  int n_run  = 0;
  int n_fail = 0;
  int n_done = 0;
  int rdy_lo = 0;
  logic [8:0] expq[$];
  logic [8:0] mon_e;

  vslc_prog_loader_if bus();

  vslc_prog_loader dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .bus        (bus.slave),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .prog_ok    (prog_ok),
    .err_len    (err_len),
    .err_csum   (err_csum)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) n_done++;
    if (wr_en) begin
      n_run++;
      if (expq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write got addr=%0d data=%h want none",
                 wr_addr, wr_data);
      end else begin
        mon_e = expq.pop_front();
        if ({wr_addr, wr_data} !== mon_e) begin
          n_fail++;
          $display("FAIL write got addr=%0d data=%h want addr=%0d data=%h",
                   wr_addr, wr_data, mon_e[8:4], mon_e[3:0]);
        end
      end
    end
  end

  task automatic chk(string nm, int act, int exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send(logic [7:0] b);
    int   n = 0;
    logic r;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    do begin
      @(negedge clk);
      r = bus.in_ready;
      if (!r) rdy_lo++;
      tick();
      n++;
    end while (!r && n < 20);
    if (!r) chk("send_timeout", 0, 1);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
  endtask

  task automatic exp_w(int a, int d);
    expq.push_back({5'(a), 4'(d)});
  endtask

  task automatic fill_from(int l);
    for (int a = l; a < CODE_DEPTH; a++)
      exp_w(a, 15);
  endtask

  task automatic wait_done(string nm, int base);
    int n = 0;
    while (n_done == base && n < 100) begin
      tick();
      n++;
    end
    chk(nm, n_done, base + 1);
  endtask

  task automatic drain(string nm);
    repeat (3) tick();
    chk(nm, expq.size(), 0);
  endtask

  int         d0;
  logic [7:0] s, b;

  initial begin
    rst        = 1'b1;
    load_start = 1'b0;
    idle();
    repeat (2) tick();
    chk("reset_outs",
        {wr_en, busy, done, prog_ok,
         err_len, err_csum, bus.in_ready}, 0);
    rst = 1'b0;
    tick();

    // L=3, good checksum, fill 3..31
    d0 = n_done;
    exp_w(0, 0); exp_w(1, 5); exp_w(2, 9);
    fill_from(3);
    start();
    chk("t1_busy", busy, 1);
    send(8'h03); send(8'h50);
    send(8'h09); send(8'hA4);
    idle();
    wait_done("t1_done", d0);
    tick();
    chk("t1_prog_ok", prog_ok, 1);
    chk("t1_err", {err_len, err_csum}, 0);
    drain("t1_queue");

    // same frame, bad checksum
    d0 = n_done;
    exp_w(0, 0); exp_w(1, 5); exp_w(2, 9);
    start();
    chk("t2_prog_ok_clr", prog_ok, 0);
    send(8'h03); send(8'h50);
    send(8'h09); send(8'hA5);
    idle();
    chk("t2_err_csum", err_csum, 1);
    repeat (40) tick();
    chk("t2_no_done", n_done, d0);
    chk("t2_prog_ok", prog_ok, 0);
    drain("t2_queue");

    // bad lengths 00 and 21
    start();
    send(8'h00);
    chk("t3_err_len0", err_len, 1);
    chk("t3_ready0", bus.in_ready, 0);
    idle();
    start();
    chk("t3_err_clr", err_len, 0);
    send(8'h21);
    chk("t3_err_len21", err_len, 1);
    chk("t3_ready21", bus.in_ready, 0);
    idle();
    repeat (5) tick();
    drain("t3_queue");

    // abort in DATA_HI, then clean L=1 frame
    start();
    chk("t6_err_clr", {err_len, err_csum}, 0);
    exp_w(0, 0);
    send(8'h03); send(8'h50);
    start();
    d0 = n_done;
    exp_w(0, 7);
    fill_from(1);
    send(8'h01); send(8'h07); send(8'hF8);
    idle();
    wait_done("t6_done", d0);
    tick();
    chk("t6_prog_ok", prog_ok, 1);
    chk("t6_busy", busy, 0);
    drain("t6_queue");

    // L=32, valid held high, no fill
    d0 = n_done;
    for (int a = 0; a < CODE_DEPTH; a++)
      exp_w(a, a % 16);
    start();
    send(8'h20);
    s = 8'h20;
    rdy_lo = 0;
    for (int k = 0; k < 16; k++) begin
      b = {4'((2*k+1) % 16), 4'((2*k) % 16)};
      s = s + b;
      send(b);
    end
    chk("t4_ready_toggle", rdy_lo, 15);
    send(8'd0 - s);
    idle();
    wait_done("t4_done", d0);
    tick();
    chk("t4_prog_ok", prog_ok, 1);
    drain("t4_queue");

    // reset mid-load
    exp_w(0, 1); exp_w(1, 2); exp_w(2, 3);
    start();
    send(8'h05); send(8'h21); send(8'h43);
    rst = 1'b1;
    tick();
    chk("t5_outs",
        {wr_en, busy, done, prog_ok,
         err_len, err_csum, bus.in_ready}, 0);
    rst = 1'b0;
    idle();
    repeat (5) tick();
    chk("t5_idle", busy, 0);
    drain("t5_queue");

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
